// File: rtl/morse_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : morse_encoder                                                   |
// | Purpose  : ASCII to Morse pulse encoder with char/word gap timing.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module morse_encoder #(
    parameter int CHAR_GAP = 5,
    parameter int WORD_GAP = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       dot_out,
    output logic       dash_out,
    output logic       char_space_out,
    output logic       word_space_out,
    output logic       err_out
);

    localparam logic [3:0] c_CHAR_GAP = 4'(CHAR_GAP);
    localparam logic [3:0] c_WORD_GAP = 4'(WORD_GAP);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYM_ON  = 3'd1,
        S_SYM_OFF = 3'd2,
        S_CSP_ON  = 3'd3,
        S_WSP_ON  = 3'd4,
        S_GAP     = 3'd5
    } state_t;

    // Returns {supported, length, pattern}; pattern is left-aligned, first
    // symbol in bit 4, 1 = dash.
    function automatic logic [8:0] f_lookup(input logic [7:0] ch);
        logic [7:0] up;
        up = (ch >= 8'h61 && ch <= 8'h7A) ? (ch - 8'h20) : ch;
        case (up)
            8'h41: f_lookup = {1'b1, 3'd2, 5'b01000};  // A
            8'h42: f_lookup = {1'b1, 3'd4, 5'b10000};  // B
            8'h43: f_lookup = {1'b1, 3'd4, 5'b10100};  // C
            8'h44: f_lookup = {1'b1, 3'd3, 5'b10000};  // D
            8'h45: f_lookup = {1'b1, 3'd1, 5'b00000};  // E
            8'h46: f_lookup = {1'b1, 3'd4, 5'b00100};  // F
            8'h47: f_lookup = {1'b1, 3'd3, 5'b11000};  // G
            8'h48: f_lookup = {1'b1, 3'd4, 5'b00000};  // H
            8'h49: f_lookup = {1'b1, 3'd2, 5'b00000};  // I
            8'h4A: f_lookup = {1'b1, 3'd4, 5'b01110};  // J
            8'h4B: f_lookup = {1'b1, 3'd3, 5'b10100};  // K
            8'h4C: f_lookup = {1'b1, 3'd4, 5'b01000};  // L
            8'h4D: f_lookup = {1'b1, 3'd2, 5'b11000};  // M
            8'h4E: f_lookup = {1'b1, 3'd2, 5'b10000};  // N
            8'h4F: f_lookup = {1'b1, 3'd3, 5'b11100};  // O
            8'h50: f_lookup = {1'b1, 3'd4, 5'b01100};  // P
            8'h51: f_lookup = {1'b1, 3'd4, 5'b11010};  // Q
            8'h52: f_lookup = {1'b1, 3'd3, 5'b01000};  // R
            8'h53: f_lookup = {1'b1, 3'd3, 5'b00000};  // S
            8'h54: f_lookup = {1'b1, 3'd1, 5'b10000};  // T
            8'h55: f_lookup = {1'b1, 3'd3, 5'b00100};  // U
            8'h56: f_lookup = {1'b1, 3'd4, 5'b00010};  // V
            8'h57: f_lookup = {1'b1, 3'd3, 5'b01100};  // W
            8'h58: f_lookup = {1'b1, 3'd4, 5'b10010};  // X
            8'h59: f_lookup = {1'b1, 3'd4, 5'b10110};  // Y
            8'h5A: f_lookup = {1'b1, 3'd4, 5'b11000};  // Z
            8'h30: f_lookup = {1'b1, 3'd5, 5'b11111};  // 0
            8'h31: f_lookup = {1'b1, 3'd5, 5'b01111};  // 1
            8'h32: f_lookup = {1'b1, 3'd5, 5'b00111};  // 2
            8'h33: f_lookup = {1'b1, 3'd5, 5'b00011};  // 3
            8'h34: f_lookup = {1'b1, 3'd5, 5'b00001};  // 4
            8'h35: f_lookup = {1'b1, 3'd5, 5'b00000};  // 5
            8'h36: f_lookup = {1'b1, 3'd5, 5'b10000};  // 6
            8'h37: f_lookup = {1'b1, 3'd5, 5'b11000};  // 7
            8'h38: f_lookup = {1'b1, 3'd5, 5'b11100};  // 8
            8'h39: f_lookup = {1'b1, 3'd5, 5'b11110};  // 9
            default: f_lookup = 9'd0;
        endcase
    endfunction

    logic [8:0] w_lut;
    logic       w_lut_ok;
    logic [2:0] w_lut_len;
    logic [4:0] w_lut_pat;

    assign w_lut     = f_lookup(char_in);
    assign w_lut_ok  = w_lut[8];
    assign w_lut_len = w_lut[7:5];
    assign w_lut_pat = w_lut[4:0];

    state_t     r_state;
    logic [2:0] r_sym_cnt;
    logic [2:0] r_len;
    logic [4:0] r_pat;
    logic [3:0] r_gap_cnt;
    logic [3:0] r_gap_len;

    // Pulse outputs are set on the same edge that enters the state they belong
    // to, so each pulse lines up exactly with its state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_sym_cnt      <= 3'd0;
            r_len          <= 3'd0;
            r_pat          <= 5'd0;
            r_gap_cnt      <= 4'd0;
            r_gap_len      <= 4'd0;
            char_ready     <= 1'b0;
            dot_out        <= 1'b0;
            dash_out       <= 1'b0;
            char_space_out <= 1'b0;
            word_space_out <= 1'b0;
            err_out        <= 1'b0;
        end else begin
            dot_out        <= 1'b0;
            dash_out       <= 1'b0;
            char_space_out <= 1'b0;
            word_space_out <= 1'b0;
            err_out        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    char_ready <= 1'b1;
                    if (char_ready && char_valid) begin
                        if (char_in == 8'h20) begin
                            r_state        <= S_WSP_ON;
                            char_ready     <= 1'b0;
                            word_space_out <= 1'b1;
                            r_gap_len      <= c_WORD_GAP;
                            r_gap_cnt      <= 4'd0;
                        end else if (w_lut_ok) begin
                            r_state    <= S_SYM_ON;
                            char_ready <= 1'b0;
                            r_len      <= w_lut_len;
                            r_sym_cnt  <= 3'd0;
                            r_pat      <= {w_lut_pat[3:0], 1'b0};
                            dash_out   <= w_lut_pat[4];
                            dot_out    <= ~w_lut_pat[4];
                        end else begin
                            err_out <= 1'b1;
                        end
                    end
                end
                S_SYM_ON: r_state <= S_SYM_OFF;
                S_SYM_OFF: begin
                    if (r_sym_cnt == r_len - 3'd1) begin
                        r_state        <= S_CSP_ON;
                        char_space_out <= 1'b1;
                        r_gap_len      <= c_CHAR_GAP;
                        r_gap_cnt      <= 4'd0;
                    end else begin
                        r_state   <= S_SYM_ON;
                        r_sym_cnt <= r_sym_cnt + 3'd1;
                        r_pat     <= {r_pat[3:0], 1'b0};
                        dash_out  <= r_pat[4];
                        dot_out   <= ~r_pat[4];
                    end
                end
                S_CSP_ON, S_WSP_ON: r_state <= S_GAP;
                S_GAP: begin
                    if (r_gap_cnt == r_gap_len - 4'd1) begin
                        r_state    <= S_IDLE;
                        char_ready <= 1'b1;
                        r_gap_cnt  <= 4'd0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    char_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_morse_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_morse_encoder                                                |
// | Purpose  : Self-checking bench for morse_encoder against a cycle timeline. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_morse_encoder;

    localparam int CHAR_GAP = 5;
    localparam int WORD_GAP = 8;
    localparam int MAXC     = 16384;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic [7:0] char_in    = 8'h00;
    logic       char_valid = 1'b0;
    logic       char_ready, dot_out, dash_out, char_space_out, word_space_out, err_out;

    morse_encoder #(.CHAR_GAP(CHAR_GAP), .WORD_GAP(WORD_GAP)) dut (
        .clk            (clk),
        .rst            (rst),
        .char_in        (char_in),
        .char_valid     (char_valid),
        .char_ready     (char_ready),
        .dot_out        (dot_out),
        .dash_out       (dash_out),
        .char_space_out (char_space_out),
        .word_space_out (word_space_out),
        .err_out        (err_out)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_pass   = 0;
    int  cyc      = 0;
    int  ready_from = 1 << 30;
    bit  in_reset = 1'b1;
    bit  rand_gaps = 1'b0;
    int  idle_left = 0;
    int  last_accept = -1;
    byte unsigned pend[$];
    bit  exp_dot[MAXC], exp_dash[MAXC], exp_csp[MAXC], exp_wsp[MAXC], exp_err[MAXC];

    string letters[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                           ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                           "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
    string digits[10]  = '{"-----", ".----", "..---", "...--", "....-",
                           ".....", "-....", "--...", "---..", "----."};

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    endtask

    function automatic string code_of(input byte unsigned ch);
        byte unsigned u;
        u = (ch >= 8'h61 && ch <= 8'h7A) ? ch - 8'h20 : ch;
        if (u >= 8'h41 && u <= 8'h5A) return letters[u - 8'h41];
        if (u >= 8'h30 && u <= 8'h39) return digits[u - 8'h30];
        return "";
    endfunction

    // Timeline model: an accept in cycle n schedules every later pulse directly.
    task automatic model_accept(input int n, input byte unsigned ch);
        string s;
        int    len;
        last_accept = n;
        if (ch == 8'h20) begin
            exp_wsp[n+1] = 1'b1;
            ready_from   = n + 2 + WORD_GAP;
        end else begin
            s   = code_of(ch);
            len = s.len();
            if (len == 0) begin
                exp_err[n+1] = 1'b1;
            end else begin
                for (int k = 0; k < len; k++) begin
                    if (s[k] == 8'h2D) exp_dash[n+1+2*k] = 1'b1;
                    else               exp_dot[n+1+2*k]  = 1'b1;
                end
                exp_csp[n+2*len+1] = 1'b1;
                ready_from = n + 2*len + 2 + CHAR_GAP;
            end
        end
    endtask

    task automatic step();
        bit rdy;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rdy = !in_reset && (cyc >= ready_from);
        check("dot",        dot_out,        exp_dot[cyc]);
        check("dash",       dash_out,       exp_dash[cyc]);
        check("char_space", char_space_out, exp_csp[cyc]);
        check("word_space", word_space_out, exp_wsp[cyc]);
        check("err",        err_out,        exp_err[cyc]);
        check("ready",      char_ready,     rdy);
        if (pend.size() > 0 && idle_left == 0) begin
            char_valid = 1'b1;
            char_in    = pend[0];
        end else begin
            char_valid = 1'b0;
            char_in    = 8'($urandom);
            if (idle_left > 0) idle_left--;
        end
        if (char_valid && rdy) begin
            model_accept(cyc, char_in);
            void'(pend.pop_front());
            idle_left = rand_gaps ? $urandom_range(0, 3) : 0;
        end
    endtask

    task automatic run_until_idle(input int limit);
        int n;
        n = 0;
        while ((pend.size() > 0 || cyc < ready_from) && n < limit) begin
            step();
            n++;
        end
        if (n >= limit) check("timeout", 1, 0);
    endtask

    task automatic async_reset(input int hold);
        #2 rst = 1'b0;
        in_reset = 1'b1;
        #1;
        check("rst_dot",   dot_out,        0);
        check("rst_dash",  dash_out,       0);
        check("rst_csp",   char_space_out, 0);
        check("rst_wsp",   word_space_out, 0);
        check("rst_err",   err_out,        0);
        check("rst_ready", char_ready,     0);
        for (int i = cyc + 1; i < MAXC; i++) begin
            exp_dot[i] = 0; exp_dash[i] = 0; exp_csp[i] = 0; exp_wsp[i] = 0; exp_err[i] = 0;
        end
        pend.delete();
        ready_from = 1 << 30;
        repeat (hold) step();
        rst        = 1'b1;
        in_reset   = 1'b0;
        ready_from = cyc + 1;
    endtask

    function automatic byte unsigned rand_char();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 2) return 8'(8'h41 + $urandom_range(0, 25));
        if (r <= 4) return 8'(8'h61 + $urandom_range(0, 25));
        if (r <= 6) return 8'(8'h30 + $urandom_range(0, 9));
        if (r == 7) return 8'h20;
        return 8'($urandom);
    endfunction

    initial begin
        int n0;
        #1 rst = 1'b0;
        repeat (3) step();
        rst        = 1'b1;
        in_reset   = 1'b0;
        ready_from = cyc + 1;
        step();

        pend.push_back(8'h52);                          // 'R'
        run_until_idle(100);
        pend.push_back(8'h54); pend.push_back(8'h6C);   // 'T','l' held back-to-back
        run_until_idle(100);
        pend.push_back(8'h20);
        run_until_idle(100);
        pend.push_back(8'h31);
        run_until_idle(100);
        pend.push_back(8'h23); pend.push_back(8'h45);   // '#' then 'E'
        run_until_idle(100);

        // Abort 'R' four cycles after its accept.
        pend.push_back(8'h52);
        n0 = 0;
        while (pend.size() > 0 && n0 < 50) begin step(); n0++; end
        n0 = last_accept;
        while (cyc < n0 + 4) step();
        async_reset(2);
        repeat (20) step();

        rand_gaps = 1'b1;
        for (int i = 0; i < 200; i++) pend.push_back(rand_char());
        run_until_idle(8000);
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
